memory_arbiter: RTL and testbench

Arbitrates the single-cycle core's instruction-fetch port and data load/store port onto one single-ported, variable-latency RAM. Sits between the datapath (fetch address from the PC, data requests driven by the decoded MemWr/MemtoReg controls) and the RAM model. The RAM returns `ramstate_t` from `cpu_types_pkg`. Data requests have priority, with a starvation guard that guarantees forward progress for fetch. Halt blocks new fetches, and RAM errors are made sticky.

---
 rtl/memory_arbiter.sv | 142 ++++++++++++++
 tb/tb_memory_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between instruction fetch
// and data load/store, with data priority and a fetch starvation guard.
`timescale 1ns/1ps

package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic [31:0] BAD_WORD = 32'hBAD1BAD1;
    localparam logic [3:0]  DMAX     = 4'(DSTARVE_MAX);

    state_t     state;
    state_t     state_n;
    logic [3:0] dcnt;
    logic [3:0] dcnt_n;
    logic       err_n;
    ramstate_t  rs;
    logic       done;
    logic       rs_err;
    logic       ireq;
    logic       dreq;
    logic       starve;

    assign rs     = ramstate_t'(ramstate);
    assign rs_err = (rs == ERROR);
    assign done   = (rs == ACCESS) || rs_err;
    assign ireq   = iREN & ~halt;
    assign dreq   = dREN | dWEN;
    // Fetch is owed the next grant once data has won DSTARVE_MAX times.
    assign starve = ireq && (dcnt == DMAX);

    // State, starvation counter and sticky error registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            dcnt  <= 4'd0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            err   <= err_n;
        end
    end

    // Grant selection, RAM strobes and requester handshakes.
    always_comb begin
        state_n  = state;
        dcnt_n   = dcnt;
        err_n    = err;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iload    = 32'd0;
        dload    = 32'd0;
        iwait    = iREN;
        dwait    = dreq;
        unique case (state)
            IDLE: begin
                if (dreq && !starve) begin
                    state_n = DGNT;
                end else if (ireq) begin
                    state_n = IGNT;
                end
            end
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iload   = rs_err ? BAD_WORD : ramload;
                if (!iREN) begin
                    state_n = IDLE;
                end else if (done) begin
                    iwait   = 1'b0;
                    state_n = IDLE;
                    dcnt_n  = 4'd0;
                    if (rs_err) err_n = 1'b1;
                end
            end
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = rs_err ? BAD_WORD : ramload;
                if (!dreq) begin
                    state_n = IDLE;
                end else if (done) begin
                    dwait   = 1'b0;
                    state_n = IDLE;
                    if (!iREN) begin
                        dcnt_n = 4'd0;
                    end else if (dcnt >= DMAX) begin
                        dcnt_n = DMAX;
                    end else begin
                        dcnt_n = dcnt + 4'd1;
                    end
                    if (rs_err) err_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the arbiter.
`timescale 1ns/1ps

module tb_memory_arbiter;

    localparam int DMAX = 4;
    localparam logic [31:0] BAD = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    int passed = 0;
    int total  = 0;

    memory_arbiter #(.DSTARVE_MAX(DMAX)) dut (
        .CLK(CLK), .RST(RST), .halt(halt),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1ns after the rising edge; outputs are sampled at the
    // falling edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; halt = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
        ramload = 32'd0; ramstate = 2'd0;
        next_cycle();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        iREN = 1'b1;
        @(negedge CLK);
        total++;
        if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'd0)
            $display("FAIL reset_strobes: got %h want 0",
                     {ramREN, ramWEN, ramaddr, ramstore});
        else passed++;
        total++;
        if ({iload, dload, err} !== 65'd0)
            $display("FAIL reset_loads: got %h want 0", {iload, dload, err});
        else passed++;
        total++;
        if ({iwait, dwait} !== 2'b10)
            $display("FAIL reset_waits: got %b want 10", {iwait, dwait});
        else passed++;
    endtask

    task automatic test_fetch();
        do_reset();
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd0;
        @(negedge CLK);
        total++;
        if ({ramREN, iwait} !== 2'b01)
            $display("FAIL fetch_c0: got %b want 01", {ramREN, iwait});
        else passed++;
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            ramstate = 2'd1;
            ramload = $urandom;
            @(negedge CLK);
            total++;
            if ({ramREN, iwait, ramaddr} !== {2'b11, 32'h40})
                $display("FAIL fetch_busy c%0d: got %h want 3_00000040", c,
                         {ramREN, iwait, ramaddr});
            else passed++;
        end
        next_cycle();
        ramstate = 2'd2; ramload = 32'h8C220004;
        @(negedge CLK);
        total++;
        if ({ramREN, iwait, iload} !== {2'b10, 32'h8C220004})
            $display("FAIL fetch_access: got %h want 2_8c220004",
                     {ramREN, iwait, iload});
        else passed++;
        next_cycle();
        iREN = 1'b0; ramstate = 2'd0;
        @(negedge CLK);
        total++;
        if ({ramREN, iload} !== 33'd0)
            $display("FAIL fetch_turnaround: got %h want 0", {ramREN, iload});
        else passed++;
    endtask

    task automatic test_starvation();
        logic [7:0] seq[$];
        string want;
        want = "DDDDIDDDDI";
        do_reset();
        iREN = 1'b1; iaddr = 32'h40;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        ramstate = 2'd2; ramload = 32'h0;
        for (int c = 0; c < 24; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                total++;
                if ({ramWEN, ramREN, dwait, ramstore} !== {3'b100, 32'hDEADBEEF})
                    $display("FAIL contention_first: got %h want 4_deadbeef",
                             {ramWEN, ramREN, dwait, ramstore});
                else passed++;
            end
            if (ramREN | ramWEN)
                seq.push_back(ramaddr == 32'h100 ? 8'h44 : 8'h49);
            next_cycle();
        end
        total++;
        if (seq.size() < 10) begin
            $display("FAIL starve_count: got %0d grants want >=10", seq.size());
        end else begin
            passed++;
            for (int k = 0; k < 10; k++) begin
                total++;
                if (seq[k] !== want[k])
                    $display("FAIL starve_seq[%0d]: got %c want %c", k,
                             seq[k], want[k]);
                else passed++;
            end
        end
        dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        halt = 1'b1; iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            total++;
            if ({ramREN, iwait} !== 2'b01)
                $display("FAIL halt_block c%0d: got %b want 01", c,
                         {ramREN, iwait});
            else passed++;
            next_cycle();
        end
        dREN = 1'b1; daddr = 32'h200; ramload = 32'hCAFE0001;
        next_cycle();
        @(negedge CLK);
        total++;
        if ({ramREN, dwait, iwait, ramaddr, dload} !==
            {3'b101, 32'h200, 32'hCAFE0001})
            $display("FAIL halt_data: got %h want 5_00000200_cafe0001",
                     {ramREN, dwait, iwait, ramaddr, dload});
        else passed++;
        halt = 1'b0; dREN = 1'b0; iREN = 1'b0;
    endtask

    task automatic test_error();
        do_reset();
        dREN = 1'b1; daddr = 32'h300; ramstate = 2'd0;
        next_cycle();
        ramstate = 2'd3; ramload = 32'h12345678;
        @(negedge CLK);
        total++;
        if ({dwait, err, dload} !== {2'b00, BAD})
            $display("FAIL error_cycle: got %h want 0_bad1bad1",
                     {dwait, err, dload});
        else passed++;
        next_cycle();
        dREN = 1'b0; ramstate = 2'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            total++;
            if (err !== 1'b1)
                $display("FAIL error_sticky c%0d: got %b want 1", c, err);
            else passed++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        iREN = 1'b1; iaddr = 32'h80; ramstate = 2'd0;
        next_cycle();
        ramstate = 2'd1;
        @(negedge CLK);
        total++;
        if ({ramREN, iwait, err} !== 3'b111)
            $display("FAIL midrst_pre: got %b want 111", {ramREN, iwait, err});
        else passed++;
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if ({ramREN, iwait, err} !== 3'b010)
            $display("FAIL midrst_post: got %b want 010", {ramREN, iwait, err});
        else passed++;
        iREN = 1'b0;
        next_cycle();
    endtask

    // Reference model: who owns the RAM, how many data wins fetch has sat
    // through, and whether an error has been seen since reset.
    int m_owner;
    int m_streak;
    bit m_err;

    task automatic test_random();
        logic [133:0] got;
        logic [133:0] exp;
        bit fin;
        bit fetch_ok;
        bit data_req;
        int r;
        do_reset();
        m_owner = 0; m_streak = 0; m_err = 0;
        for (int c = 0; c < 600; c++) begin
            RST   = ($urandom_range(0, 99) == 0);
            halt  = ($urandom_range(0, 9) == 0);
            iREN  = ($urandom_range(0, 3) != 0);
            dREN  = ($urandom_range(0, 4) < 2);
            dWEN  = ($urandom_range(0, 3) == 0);
            iaddr = $urandom; daddr = $urandom;
            dstore = $urandom; ramload = $urandom;
            r = $urandom_range(0, 15);
            ramstate = (r < 4) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
            @(negedge CLK);
            fin = (ramstate == 2'd2) || (ramstate == 2'd3);
            data_req = dREN || dWEN;
            exp = '0;
            exp[133] = (m_owner == 1) || (m_owner == 2 && dREN && !dWEN);
            exp[132] = (m_owner == 2) && dWEN;
            exp[131] = iREN && !(m_owner == 1 && fin);
            exp[130] = data_req && !(m_owner == 2 && fin);
            exp[129:128] = {1'b0, m_err};
            if (m_owner == 1) begin
                exp[127:96] = iaddr;
                exp[63:32]  = (ramstate == 2'd3) ? BAD : ramload;
            end else if (m_owner == 2) begin
                exp[127:96] = daddr;
                exp[95:64]  = dstore;
                exp[31:0]   = (ramstate == 2'd3) ? BAD : ramload;
            end
            got = {ramREN, ramWEN, iwait, dwait, 1'b0, err,
                   ramaddr, ramstore, iload, dload};
            total++;
            if (got !== exp)
                $display("FAIL random c%0d: got %h want %h", c, got, exp);
            else passed++;
            @(posedge CLK);
            fetch_ok = iREN && !halt;
            if (RST) begin
                m_owner = 0; m_streak = 0; m_err = 0;
            end else if (m_owner == 0) begin
                if (data_req && !(fetch_ok && m_streak == DMAX)) m_owner = 2;
                else if (fetch_ok) m_owner = 1;
            end else if (m_owner == 1) begin
                if (!iREN) m_owner = 0;
                else if (fin) begin
                    m_owner = 0; m_streak = 0;
                    if (ramstate == 2'd3) m_err = 1;
                end
            end else begin
                if (!data_req) m_owner = 0;
                else if (fin) begin
                    m_owner = 0;
                    m_streak = iREN ? ((m_streak + 1 > DMAX) ? DMAX : m_streak + 1) : 0;
                    if (ramstate == 2'd3) m_err = 1;
                end
            end
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_starvation();
        test_halt();
        test_error();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
